// File: rtl/qspi_flash_ctrl_model.sv
// qspi_flash_ctrl_model: command-driven quad-SPI NOR flash storage and timing model
module qspi_flash_ctrl_model #(
  parameter int ADDR_WIDTH   = 12,
  parameter int PAGE_BYTES   = 16,
  parameter int SECTOR_BYTES = 256,
  parameter int LEN_WIDTH    = 8,
  parameter int DUMMY_CYCLES = 4,
  parameter int PROG_CYCLES  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [3:0]            wr_nibble,
  output logic                  rd_valid,
  output logic [3:0]            rd_nibble,
  output logic                  rd_last,
  output logic                  busy,
  output logic                  wel,
  output logic                  err
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int PW = $clog2(PAGE_BYTES);
  localparam int SW = $clog2(SECTOR_BYTES);
  localparam int TMAX = SECTOR_BYTES > DUMMY_CYCLES ?
                        (SECTOR_BYTES > PROG_CYCLES ? SECTOR_BYTES : PROG_CYCLES) :
                        (DUMMY_CYCLES > PROG_CYCLES ? DUMMY_CYCLES : PROG_CYCLES);
  localparam int TW = $clog2(TMAX + 1);
  localparam logic [2:0] OP_WREN = 3'd1, OP_WRDI = 3'd2, OP_READ = 3'd3, OP_PROG = 3'd4, OP_ERASE = 3'd5;
  typedef enum logic [2:0] {IDLE, RD_DUMMY, RD_DATA, PROG_DATA, PROG_WAIT, ERASE} state_t;
  state_t state, state_d;
  // Cells are stored inverted so the power-up all-zero state reads back as erased 0xFF.
  logic [7:0] mem_n [DEPTH];
  logic [ADDR_WIDTH-1:0] addr, mem_wa;
  logic [LEN_WIDTH-1:0] cnt;
  logic [TW-1:0] tmr;
  logic [3:0] hi;
  logic [7:0] rd_byte, mem_wd_n;
  logic ph, accept, tmr_zero, last_byte, erase_done, nib_lo, mem_we, wel_clr;
  assign accept     = cmd_valid & cmd_ready;
  assign tmr_zero   = tmr == '0;
  assign last_byte  = cnt == '0;
  assign erase_done = tmr == TW'(SECTOR_BYTES - 1);
  assign nib_lo     = (state == PROG_DATA) & wr_valid & ph;
  assign wel_clr    = (state == PROG_WAIT & tmr_zero) | (state == ERASE & erase_done);
  assign cmd_ready  = state == IDLE;
  assign busy       = state != IDLE;
  assign wr_ready   = state == PROG_DATA;
  assign rd_valid   = state == RD_DATA;
  assign rd_byte    = ~mem_n[addr];
  assign rd_nibble  = rd_valid ? (ph ? rd_byte[3:0] : rd_byte[7:4]) : 4'h0;
  assign rd_last    = rd_valid & ph & last_byte;
  assign mem_we     = ~reset & (nib_lo | state == ERASE);
  assign mem_wa     = state == ERASE ? {addr[ADDR_WIDTH-1:SW], tmr[SW-1:0]} : addr;
  assign mem_wd_n   = state == ERASE ? 8'h00 : mem_n[addr] | ~{hi, wr_nibble};
  always_comb begin
    state_d = state;
    case (state)
      IDLE:      if (accept) state_d = cmd_op == OP_READ ? RD_DUMMY :
                                       cmd_op == OP_PROG & wel ? PROG_DATA :
                                       cmd_op == OP_ERASE & wel ? ERASE : IDLE;
      RD_DUMMY:  if (tmr_zero) state_d = RD_DATA;
      RD_DATA:   if (ph & last_byte) state_d = IDLE;
      PROG_DATA: if (nib_lo & last_byte) state_d = PROG_WAIT;
      PROG_WAIT: if (tmr_zero) state_d = IDLE;
      ERASE:     if (erase_done) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      wel   <= 1'b0;
      err   <= 1'b0;
      ph    <= 1'b0;
    end else begin
      state <= state_d;
      err   <= accept & (cmd_op > OP_ERASE | (cmd_op == OP_PROG | cmd_op == OP_ERASE) & ~wel);
      wel   <= wel_clr ? 1'b0 : accept & cmd_op == OP_WREN ? 1'b1 : accept & cmd_op == OP_WRDI ? 1'b0 : wel;
      ph    <= accept ? 1'b0 : (state == RD_DATA | (state == PROG_DATA & wr_valid)) ? ~ph : ph;
    end
  end
  always_ff @(posedge clk) begin
    if (accept) begin
      addr <= cmd_addr;
      cnt  <= cmd_len;
    end
    if (state == RD_DATA & ph) begin
      addr <= addr + 1'b1;
      cnt  <= cnt - 1'b1;
    end
    if (nib_lo) begin
      addr <= {addr[ADDR_WIDTH-1:PW], addr[PW-1:0] + 1'b1};
      cnt  <= cnt - 1'b1;
    end
    if (state == PROG_DATA & wr_valid & ~ph) hi <= wr_nibble;
    tmr <= accept ? (cmd_op == OP_READ ? TW'(DUMMY_CYCLES - 1) : '0) :
           nib_lo ? TW'(PROG_CYCLES - 1) :
           state == ERASE ? tmr + 1'b1 :
           tmr_zero ? tmr : tmr - 1'b1;
  end
  always_ff @(posedge clk) if (mem_we) mem_n[mem_wa] <= mem_wd_n;
endmodule

// File: tb/tb_qspi_flash_ctrl_model.sv
// tb_qspi_flash_ctrl_model: directed checks of command, read, program and erase behaviour
module tb_qspi_flash_ctrl_model;
  logic clk = 1'b0, reset = 1'b1, cmd_valid = 1'b0, wr_valid = 1'b0;
  logic [2:0] cmd_op = '0;
  logic [11:0] cmd_addr = '0;
  logic [7:0] cmd_len = '0;
  logic [3:0] wr_nibble = '0;
  logic cmd_ready, wr_ready, rd_valid, rd_last, busy, wel, err;
  logic [3:0] rd_nibble;
  logic [7:0] rb [256];
  logic [7:0] acc;
  int n_vec = 0, n_err = 0, k;
  always #5 clk = ~clk;
  qspi_flash_ctrl_model dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_nibble(wr_nibble),
    .rd_valid(rd_valid), .rd_nibble(rd_nibble), .rd_last(rd_last),
    .busy(busy), .wel(wel), .err(err)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic issue(input logic [2:0] op, input logic [11:0] a, input logic [7:0] l);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_len = l;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask
  task automatic wren();
    issue(3'd1, 12'h000, 8'h00);
    chk("wren_wel", wel, 1);
  endtask
  task automatic rd(input logic [11:0] a, input int l);
    int c;
    issue(3'd3, a, 8'(l));
    chk("rd_err", err, 0);
    c = 0;
    while (!rd_valid && c < 20) begin
      @(negedge clk);
      c++;
    end
    chk("rd_latency", c, 4);
    for (int j = 0; j < 2 * (l + 1); j++) begin
      chk("rd_valid_last", {rd_valid, rd_last}, {1'b1, j == 2 * l + 1});
      if (j % 2 == 0) rb[j / 2][7:4] = rd_nibble;
      else rb[j / 2][3:0] = rd_nibble;
      @(negedge clk);
    end
    chk("rd_idle_after", busy, 0);
  endtask
  task automatic prog(input logic [11:0] a, input logic [31:0] d, input int n);
    int c;
    issue(3'd4, a, 8'(n - 1));
    for (int j = 0; j < 2 * n; j++) begin
      wr_valid = 1'b1;
      wr_nibble = d[4 * (2 * n - 1 - j) +: 4];
      @(negedge clk);
      if (j == 0) begin
        wr_valid = 1'b0;
        @(negedge clk);
      end
    end
    wr_valid = 1'b0;
    c = 0;
    while (busy && c < 50) begin
      c++;
      @(negedge clk);
    end
    chk("prog_busy_cycles", c, 8);
    chk("prog_wel_after", wel, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_wel", wel, 0);
    chk("rst_err", err, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_wr_ready", wr_ready, 0);
    reset = 1'b0;
    rd(12'h000, 1);
    chk("t1_b0", rb[0], 8'hFF);
    chk("t1_b1", rb[1], 8'hFF);
    issue(3'd4, 12'h010, 8'h00);
    chk("t2_err", err, 1);
    chk("t2_wr_ready", wr_ready, 0);
    chk("t2_busy", busy, 0);
    @(negedge clk);
    chk("t2_err_pulse", err, 0);
    wr_valid = 1'b1; wr_nibble = 4'h0;
    @(negedge clk);
    wr_valid = 1'b0;
    rd(12'h010, 0);
    chk("t2_byte", rb[0], 8'hFF);
    issue(3'd6, 12'h000, 8'h00);
    chk("rsv_err", err, 1);
    chk("rsv_busy", busy, 0);
    wren();
    prog(12'h00E, 32'hA53C0FF0, 4);
    rd(12'h00E, 1);
    chk("t3_00e", rb[0], 8'hA5);
    chk("t3_00f", rb[1], 8'h3C);
    rd(12'h000, 1);
    chk("t3_000", rb[0], 8'h0F);
    chk("t3_001", rb[1], 8'hF0);
    rd(12'h010, 0);
    chk("t3_010", rb[0], 8'hFF);
    wren();
    prog(12'h00E, 32'h5A, 1);
    rd(12'h00E, 0);
    chk("t4_and", rb[0], 8'h00);
    wren();
    prog(12'h100, 32'h12, 1);
    wren();
    prog(12'hFFF, 32'h77, 1);
    wren();
    issue(3'd5, 12'h0A7, 8'h00);
    k = 0;
    while (busy && k < 400) begin
      k++;
      @(negedge clk);
    end
    chk("t5_busy_cycles", k, 256);
    chk("t5_wel_after", wel, 0);
    rd(12'h000, 255);
    acc = 8'hFF;
    for (int i = 0; i < 256; i++) acc &= rb[i];
    chk("t5_sector_ff", acc, 8'hFF);
    rd(12'h100, 0);
    chk("t5_100_kept", rb[0], 8'h12);
    wren();
    prog(12'h110, 32'h11, 1);
    wren();
    prog(12'h1F0, 32'h22, 1);
    wren();
    issue(3'd5, 12'h1C3, 8'h00);
    repeat (100) @(negedge clk);
    chk("t6_busy_mid", busy, 1);
    chk("t6_wel_mid", wel, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_wel", wel, 0);
    chk("t6_rst_ready", cmd_ready, 1);
    reset = 1'b0;
    rd(12'h100, 0);
    chk("t6_100_erased", rb[0], 8'hFF);
    rd(12'h110, 0);
    chk("t6_110_erased", rb[0], 8'hFF);
    rd(12'h1F0, 0);
    chk("t6_1f0_kept", rb[0], 8'h22);
    wren();
    prog(12'h000, 32'hC3, 1);
    rd(12'hFFF, 1);
    chk("t6_wrap_fff", rb[0], 8'h77);
    chk("t6_wrap_000", rb[1], 8'hC3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
